// File: rtl/ours_bdg_x2p_pmux.sv
`timescale 1ns/1ps
// APB fan-out: routes each master transfer to one of NUM_SLV slaves by address window,
// completes unmapped or stalled transfers with an error, and logs error completions.
module ours_bdg_x2p_pmux #(
  parameter int unsigned                NUM_SLV  = 4,
  parameter int unsigned                ADDR_W   = 32,
  parameter int unsigned                DATA_W   = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_BASE = {32'h3000, 32'h2000, 32'h1000, 32'h0000},
  parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_MASK = {4{32'hFFFF_F000}},
  parameter int unsigned                TIMEOUT  = 16,
  parameter int unsigned                CNT_W    = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  // Master side
  input  logic                        pm_psel,
  input  logic                        pm_penable,
  input  logic [ADDR_W-1:0]           pm_paddr,
  input  logic                        pm_pwrite,
  input  logic [DATA_W-1:0]           pm_pwdata,
  input  logic [DATA_W/8-1:0]         pm_pstrb,
  input  logic [2:0]                  pm_pprot,
  output logic                        pm_pready,
  output logic [DATA_W-1:0]           pm_prdata,
  output logic                        pm_pslverr,
  // Slave side
  output logic [NUM_SLV-1:0]          ps_psel,
  output logic                        ps_penable,
  output logic [ADDR_W-1:0]           ps_paddr,
  output logic                        ps_pwrite,
  output logic [DATA_W-1:0]           ps_pwdata,
  output logic [DATA_W/8-1:0]         ps_pstrb,
  output logic [2:0]                  ps_pprot,
  input  logic [NUM_SLV-1:0]          ps_pready,
  input  logic [NUM_SLV*DATA_W-1:0]   ps_prdata,
  input  logic [NUM_SLV-1:0]          ps_pslverr,
  // Error log
  output logic [CNT_W-1:0]            err_cnt,
  output logic [ADDR_W-1:0]           err_addr,
  output logic                        err_timeout
);

  localparam int unsigned SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic               r_miss;
  logic [TO_W-1:0]    r_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [ADDR_W-1:0]  r_err_addr;
  logic               r_err_timeout;

  logic               w_dec_hit;
  logic [SEL_W-1:0]   w_dec_sel;
  logic               w_slv_ready;
  logic               w_slv_err;
  logic [DATA_W-1:0]  w_slv_rdata;
  logic               w_setup;
  logic               w_access;
  logic               w_done_miss;
  logic               w_done_slv;
  logic               w_done_to;
  logic               w_done;

  // Walk downwards so the lowest-index hitting window is the one left standing.
  always_comb begin
    w_dec_hit = 1'b0;
    w_dec_sel = '0;
    for (int s = NUM_SLV - 1; s >= 0; s--) begin
      if ((pm_paddr & SLV_MASK[s*ADDR_W +: ADDR_W]) == SLV_BASE[s*ADDR_W +: ADDR_W]) begin
        w_dec_hit = 1'b1;
        w_dec_sel = SEL_W'(s);
      end
    end
  end

  always_comb begin
    w_slv_ready = 1'b0;
    w_slv_err   = 1'b0;
    w_slv_rdata = '0;
    for (int s = 0; s < NUM_SLV; s++) begin
      if (r_sel == SEL_W'(s)) begin
        w_slv_ready = ps_pready[s];
        w_slv_err   = ps_pslverr[s];
        w_slv_rdata = ps_prdata[s*DATA_W +: DATA_W];
      end
    end
  end

  // Gating with aresetn keeps every handshake output low for the whole reset window.
  assign w_setup     = aresetn & (r_state == StIdle) & pm_psel & ~pm_penable;
  assign w_access    = aresetn & (r_state == StAccess) & pm_psel;
  assign w_done_miss = w_access & r_miss;
  assign w_done_slv  = w_access & ~r_miss & w_slv_ready;
  assign w_done_to   = w_access & ~r_miss & ~w_slv_ready & (r_cnt == TO_LAST);
  assign w_done      = w_done_miss | w_done_slv | w_done_to;

  always_comb begin
    ps_psel = '0;
    for (int s = 0; s < NUM_SLV; s++) begin
      if ((w_setup & w_dec_hit & (w_dec_sel == SEL_W'(s))) |
          (w_access & ~r_miss & (r_sel == SEL_W'(s)))) begin
        ps_psel[s] = 1'b1;
      end
    end
  end

  assign ps_penable = w_access & ~r_miss & pm_penable;
  assign ps_paddr   = pm_paddr;
  assign ps_pwrite  = pm_pwrite;
  assign ps_pwdata  = pm_pwdata;
  assign ps_pstrb   = pm_pstrb;
  assign ps_pprot   = pm_pprot;

  assign pm_pready  = w_done;
  assign pm_prdata  = w_done_slv ? w_slv_rdata : '0;
  assign pm_pslverr = w_done_miss | w_done_to | (w_done_slv & w_slv_err);

  assign err_cnt     = r_err_cnt;
  assign err_addr    = r_err_addr;
  assign err_timeout = r_err_timeout;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= StIdle;
      r_sel         <= '0;
      r_miss        <= 1'b0;
      r_cnt         <= '0;
      r_err_cnt     <= '0;
      r_err_addr    <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_done_to;
      if (pm_pslverr) begin
        r_err_addr <= pm_paddr;
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
      end
      unique case (r_state)
        StIdle: begin
          if (w_setup) begin
            r_state <= StAccess;
            r_sel   <= w_dec_sel;
            r_miss  <= ~w_dec_hit;
            r_cnt   <= '0;
          end
        end
        StAccess: begin
          // Completion and master abort both return to idle; an abort logs nothing.
          if (!pm_psel || w_done) begin
            r_state <= StIdle;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/ours_bdg_x2p_pmux.md
Name: ours_bdg_x2p_pmux

Overview:
APB fan-out stage directly downstream of the bridge's APB decode/handshake stage. It takes that stage's single APB master port and routes each transfer to one of NUM_SLV peripherals by address window. It muxes the completion back to the master. Unmapped addresses complete with an error, and a per-transfer timeout completes with an error if a selected slave never raises pready. It also keeps an error counter and captures the last error address.

Parameters:
NUM_SLV, 4, number of slave ports (1..16)
ADDR_W, 32, paddr width
DATA_W, 32, pwdata/prdata width (pstrb width = DATA_W/8)
SLV_BASE, {32'h3000,32'h2000,32'h1000,32'h0000}, packed NUM_SLV*ADDR_W; slot s = bits [s*ADDR_W +: ADDR_W]
SLV_MASK, {4{32'hFFFF_F000}}, packed NUM_SLV*ADDR_W; slave s hits when (paddr & MASK[s]) == BASE[s]
TIMEOUT, 16, ACCESS cycles allowed before forced error completion (>=2)
CNT_W, 8, error counter width

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
pm_psel  in  1  master select
pm_penable  in  1  master enable
pm_paddr  in  ADDR_W  address
pm_pwrite  in  1  1=write
pm_pwdata  in  DATA_W  write data
pm_pstrb  in  DATA_W/8  write strobes
pm_pprot  in  3  protection
pm_pready  out  1  completion to master
pm_prdata  out  DATA_W  read data to master
pm_pslverr  out  1  error to master
ps_psel  out  NUM_SLV  one-hot slave select
ps_penable  out  1  shared enable
ps_paddr/ps_pwrite/ps_pwdata/ps_pstrb/ps_pprot  out  as master  shared, driven from pm_* unchanged
ps_pready  in  NUM_SLV  per-slave ready
ps_prdata  in  NUM_SLV*DATA_W  per-slave read data, slot s at [s*DATA_W +: DATA_W]
ps_pslverr  in  NUM_SLV  per-slave error
err_cnt  out  CNT_W  saturating count of error completions (decode + timeout + slave pslverr)
err_addr  out  ADDR_W  paddr of the most recent error completion
err_timeout  out  1  one-cycle pulse on timeout completion

Behaviour:
- Reset (async assert, sync release): state IDLE; rff_sel=0, rff_miss=0, timeout count=0, err_cnt=0, err_addr=0, err_timeout=0. While aresetn=0, ps_psel, ps_penable and pm_pready are forced 0, and pm_prdata/pm_pslverr are 0.
- States: IDLE, ACCESS.
- IDLE:
  - pm_psel=1 & pm_penable=0 is SETUP. Decode combinationally: lowest-index hitting s wins. Drive ps_psel[s]=1 the same cycle; ps_penable=0.
  - Register rff_sel=s and rff_miss=(no hit). Go to ACCESS.
  - On a miss, ps_psel stays all-zero.
  - pm_pready=0 in IDLE.
- ACCESS:
  - While pm_psel=1 and hit: ps_psel[rff_sel]=1, ps_penable=pm_penable, and the timeout count increments each cycle.
  - Completion, the first of:
    - (a) rff_miss: pm_pready=1, pm_pslverr=1, pm_prdata=0 in the first ACCESS cycle (zero wait).
    - (b) ps_pready[rff_sel]=1: pm_pready=1; pm_prdata/pm_pslverr taken from slot rff_sel the same cycle (combinational, zero added wait).
    - (c) count reaches TIMEOUT-1 without (b): pm_pready=1, pm_pslverr=1, pm_prdata=0; err_timeout pulses the next cycle. The slave is abandoned: ps_psel drops when the master drops psel.
  - (b) has priority over (c) in the same cycle.
  - On completion: go to IDLE and clear the count. A back-to-back SETUP on the next cycle is accepted.
  - pm_psel=0 in ACCESS without completion (protocol abort): go to IDLE, clear the count, no error logged.
- Outputs pm_pready, pm_prdata and pm_pslverr are 0 whenever no completion is being signalled.
- Error logging:
  - Trigger: any completion with pm_pslverr=1.
  - err_cnt increments next cycle and saturates at all-ones.
  - err_addr loads pm_paddr next cycle.
- Shared ps_* address/control/data outputs are pure pass-through in all states.
- Reset mid-transfer: outputs drop immediately. After release the block is in IDLE and ignores a held pm_penable=1 until a fresh SETUP (pm_penable=0) is seen.

Test Plan:
- Write paddr=0x2004, pwdata=0xA5A5_0001; slave2 pready on the 3rd ACCESS cycle -> ps_psel=4'b0100 from SETUP; pm_pready on that cycle; pm_pslverr=0; err_cnt=0.
- Read 0x1010; slave1 pready=1 in the first ACCESS cycle with prdata=0xDEAD_BEEF -> pm_prdata=0xDEAD_BEEF; transfer ends in 2 cycles total.
- Read unmapped 0x8000 -> ps_psel=0 throughout; pm_pready=1, pm_pslverr=1 in the first ACCESS cycle; err_cnt=1; err_addr=0x8000.
- Slave0 never ready, TIMEOUT=16 -> pm_pready=1, pslverr=1 on the 16th ACCESS cycle; err_timeout pulses once; slave pready arriving on that exact cycle instead yields slave data with no error.
- 255 then 300 error transfers with CNT_W=8 -> err_cnt=255 and holds.
- Assert aresetn=0 in ACCESS, release, then drive pm_penable=1 without SETUP -> no ps_psel; a new SETUP to 0x3000 proceeds normally.
